scan_pattern_driver: RTL

- Tester-side initiator for the 8-bit mux-D scan chain: serially loads a stimulus pattern, pulses a functional capture, then unloads the captured response.
- Drives the chain's scan_enable/scan_in and samples its scan_out.
- Sits between the on-chip test controller (start/pattern/result handshake) and the scan chain(s).

---
 rtl/scan_pattern_driver.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/scan_pattern_driver.sv
// scan_pattern_driver: tester-side initiator for a mux-D scan chain.
// Serially loads a stimulus pattern (LSB first), holds scan_enable low for
// CAPTURE_CYCLES functional capture edges, then unloads the captured
// response into result_out and pulses done.
// Optional feature macro: SCAN_COMPARE_EN adds expected/mask comparison
// with a registered mismatch flag and a saturating fail counter.
module scan_pattern_driver #(
  parameter int CHAIN_LEN      = 8,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
`ifdef SCAN_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] expected_in,
  input  logic [CHAIN_LEN-1:0] mask_in,
  output logic                 mismatch,
  output logic [7:0]           fail_count,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result_out,
  output logic                 scan_enable,
  output logic                 scan_in,
  input  logic                 scan_out
);

  localparam int CW  = $clog2(CHAIN_LEN);
  localparam int CCW = $clog2(CAPTURE_CYCLES + 1);

  localparam logic [CW-1:0]  BIT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CCW-1:0] CAP_LAST = CCW'(CAPTURE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_CAPTURE   = 3'd2,
    S_SHIFT_OUT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t               state_q,   state_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic [CCW-1:0]       cap_q,     cap_d;
  logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
  logic [CHAIN_LEN-1:0] shadow_q,  shadow_d;
  logic [CHAIN_LEN-1:0] result_q,  result_d;
`ifdef SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] expected_q, expected_d;
  logic [CHAIN_LEN-1:0] mask_q,     mask_d;
  logic                 mismatch_q, mismatch_d;
  logic [7:0]           fail_q,     fail_d;
`endif

  // State, counters and datapath registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cap_q      <= '0;
      pattern_q  <= '0;
      shadow_q   <= '0;
      result_q   <= '0;
`ifdef SCAN_COMPARE_EN
      expected_q <= '0;
      mask_q     <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      pattern_q  <= pattern_d;
      shadow_q   <= shadow_d;
      result_q   <= result_d;
`ifdef SCAN_COMPARE_EN
      expected_q <= expected_d;
      mask_q     <= mask_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
`endif
    end
  end

  // Next-state logic: sequencing, bit/capture counting, shadow sampling and result publish.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    pattern_d  = pattern_q;
    shadow_d   = shadow_q;
    result_d   = result_q;
`ifdef SCAN_COMPARE_EN
    expected_d = expected_q;
    mask_d     = mask_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pattern_d  = pattern_in;
          cnt_d      = '0;
          state_d    = S_SHIFT_IN;
`ifdef SCAN_COMPARE_EN
          expected_d = expected_in;
          mask_d     = mask_in;
          mismatch_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT_IN: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          cap_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CAPTURE: begin
        if (cap_q == CAP_LAST) begin
          cap_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT_OUT;
        end else begin
          cap_d = cap_q + CCW'(1);
        end
      end
      S_SHIFT_OUT: begin
        // scan_out presents chain bit k before this cycle's shift.
        shadow_d[cnt_q] = scan_out;
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          result_d = shadow_d;
          state_d  = S_DONE;
`ifdef SCAN_COMPARE_EN
          mismatch_d = |((shadow_d ^ expected_q) & ~mask_q);
          if (mismatch_d && (fail_q != 8'hFF)) begin
            fail_d = fail_q + 8'd1;
          end else begin
            fail_d = fail_q;
          end
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state, bit counter and latched pattern only.
  always_comb begin
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_SHIFT_IN: begin
        scan_enable = 1'b1;
        scan_in     = pattern_q[cnt_q];
        busy        = 1'b1;
      end
      S_CAPTURE: begin
        busy = 1'b1;
      end
      S_SHIFT_OUT: begin
        scan_enable = 1'b1;
        busy        = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign result_out = result_q;
`ifdef SCAN_COMPARE_EN
  assign mismatch   = mismatch_q;
  assign fail_count = fail_q;
`endif

endmodule
